// File: rtl/iir_notch_coeff_ctrl.sv
// Coefficient-update scheduler for the 2.4 MHz -> 1 MHz notch chain: shadow banks, round-robin commit FSM,
// bypass sequencing and status counters. Define IIR_CTRL_OVF_MON_EN to build the overflow/underflow counters.
module iir_notch_coeff_ctrl #(
   parameter int COEFF_WIDTH   = 20,
   parameter int COEFF_DEPTH   = 5,
   parameter int FLUSH_SAMPLES = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               valid_in,
   input  logic                               cfg_wr_en,
   input  logic                               cfg_sel,
   input  logic [2:0]                         cfg_addr,
   input  logic [COEFF_WIDTH-1:0]             cfg_wdata,
   output logic                               cfg_err,
   input  logic [1:0]                         commit_req,
   output logic [1:0]                         commit_done,
   output logic                               busy,
   input  logic [1:0]                         user_bypass,
   output logic                               bypass_1MHz,
   output logic                               bypass_2_4MHz,
   output logic                               coeff_wr_en_1MHz,
   output logic                               coeff_wr_en_2_4MHz,
   output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_1MHz,
   output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_2_4MHz,
   input  logic                               overflow_1MHz,
   input  logic                               underflow_1MHz,
   input  logic                               overflow_2_4MHz,
   input  logic                               underflow_2_4MHz,
   output logic [2*CNT_WIDTH-1:0]             ovf_cnt,
   output logic [2*CNT_WIDTH-1:0]             udf_cnt
);

   typedef enum logic [1:0] {IDLE, FLUSH, LOAD, SETTLE} state_t;

   localparam int BANK_W = COEFF_WIDTH * COEFF_DEPTH;
   localparam int SCNT_W = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(FLUSH_SAMPLES - 1);

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                prio_q, prio_d;
   logic [1:0]          pending_q, pending_d;
   logic [1:0]          loaded_q, loaded_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;
   logic [BANK_W-1:0]   bank_q [2];
   logic [BANK_W-1:0]   bank_d [2];
   logic                cfg_err_q, cfg_err_d;
   logic [1:0]          commit_done_q, commit_done_d;
   logic [1:0]          coeff_wr_q, coeff_wr_d;
   logic [1:0]          bypass_q, bypass_d;
   logic                last_sample;
   logic                write_blocked;
   logic                addr_ok;

   // pending[g] is released at grant so that a request arriving during service re-arms it
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      prio_d        = prio_q;
      pending_d     = pending_q;
      loaded_d      = loaded_q;
      scnt_d        = scnt_q;
      commit_done_d = 2'b00;
      last_sample   = valid_in && (scnt_q == SCNT_LAST);

      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               grant_d            = (pending_q == 2'b11) ? prio_q : pending_q[1];
               pending_d[grant_d] = 1'b0;
               scnt_d             = '0;
               state_d            = FLUSH;
            end
         end
         FLUSH: begin
            if (valid_in) begin
               scnt_d = scnt_q + SCNT_W'(1);
               if (last_sample) begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            loaded_d[grant_q] = 1'b1;
            scnt_d            = '0;
            state_d           = SETTLE;
         end
         SETTLE: begin
            if (valid_in) begin
               scnt_d = scnt_q + SCNT_W'(1);
               if (last_sample) begin
                  commit_done_d[grant_q] = 1'b1;
                  prio_d                 = ~grant_q;
                  state_d                = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      pending_d = pending_d | commit_req;

      coeff_wr_d = 2'b00;
      if (state_d == LOAD) begin
         coeff_wr_d[grant_d] = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
         bypass_d[i] = user_bypass[i] | ~loaded_d[i] | ((state_d != IDLE) && (grant_d == 1'(i)));
      end
   end

   // The granted bank is frozen while its filter is being flushed and loaded
   always_comb begin
      write_blocked = ((state_q == FLUSH) || (state_q == LOAD)) && (cfg_sel == grant_q);
      addr_ok       = int'(cfg_addr) < COEFF_DEPTH;
      cfg_err_d     = cfg_wr_en && (!addr_ok || write_blocked);
      bank_d[0]     = bank_q[0];
      bank_d[1]     = bank_q[1];
      if (cfg_wr_en && addr_ok && !write_blocked) begin
         for (int k = 0; k < COEFF_DEPTH; k++) begin
            if (cfg_addr == 3'(k)) begin
               bank_d[cfg_sel][k*COEFF_WIDTH +: COEFF_WIDTH] = cfg_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         prio_q        <= 1'b1;
         pending_q     <= 2'b00;
         loaded_q      <= 2'b00;
         scnt_q        <= '0;
         bank_q[0]     <= '0;
         bank_q[1]     <= '0;
         cfg_err_q     <= 1'b0;
         commit_done_q <= 2'b00;
         coeff_wr_q    <= 2'b00;
         bypass_q      <= 2'b11;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         prio_q        <= prio_d;
         pending_q     <= pending_d;
         loaded_q      <= loaded_d;
         scnt_q        <= scnt_d;
         bank_q[0]     <= bank_d[0];
         bank_q[1]     <= bank_d[1];
         cfg_err_q     <= cfg_err_d;
         commit_done_q <= commit_done_d;
         coeff_wr_q    <= coeff_wr_d;
         bypass_q      <= bypass_d;
      end
   end

   assign busy               = (state_q != IDLE);
   assign cfg_err            = cfg_err_q;
   assign commit_done        = commit_done_q;
   assign bypass_1MHz        = bypass_q[0];
   assign bypass_2_4MHz      = bypass_q[1];
   assign coeff_wr_en_1MHz   = coeff_wr_q[0];
   assign coeff_wr_en_2_4MHz = coeff_wr_q[1];
   assign coeff_out_1MHz     = bank_q[0];
   assign coeff_out_2_4MHz   = bank_q[1];

`ifdef IIR_CTRL_OVF_MON_EN
   logic [CNT_WIDTH-1:0] ovf_q [2];
   logic [CNT_WIDTH-1:0] ovf_d [2];
   logic [CNT_WIDTH-1:0] udf_q [2];
   logic [CNT_WIDTH-1:0] udf_d [2];
   logic [1:0]           ovf_flag;
   logic [1:0]           udf_flag;

   assign ovf_flag = {overflow_2_4MHz, overflow_1MHz};
   assign udf_flag = {underflow_2_4MHz, underflow_1MHz};

   // Saturating event counters, one pair per filter
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ovf_d[i] = (ovf_flag[i] && !(&ovf_q[i])) ? ovf_q[i] + CNT_WIDTH'(1) : ovf_q[i];
         udf_d[i] = (udf_flag[i] && !(&udf_q[i])) ? udf_q[i] + CNT_WIDTH'(1) : udf_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            ovf_q[i] <= '0;
            udf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            ovf_q[i] <= ovf_d[i];
            udf_q[i] <= udf_d[i];
         end
      end
   end

   assign ovf_cnt = {ovf_q[1], ovf_q[0]};
   assign udf_cnt = {udf_q[1], udf_q[0]};
`else
   logic unused_status;
   assign unused_status = ^{overflow_1MHz, underflow_1MHz, overflow_2_4MHz, underflow_2_4MHz};
   assign ovf_cnt = '0;
   assign udf_cnt = '0;
`endif

endmodule

// File: tb/tb_iir_notch_coeff_ctrl.sv
// Self-checking bench for iir_notch_coeff_ctrl: per-cycle behavioural model plus directed literal checks.
// Counter expectations follow IIR_CTRL_OVF_MON_EN when the bench is built with it.
module tb_iir_notch_coeff_ctrl;

   localparam int W   = 20;
   localparam int D   = 5;
   localparam int N   = 4;
   localparam int CW  = 8;
   localparam int BW  = W * D;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic          cfg_wr_en;
   logic          cfg_sel;
   logic [2:0]    cfg_addr;
   logic [W-1:0]  cfg_wdata;
   logic          cfg_err;
   logic [1:0]    commit_req;
   logic [1:0]    commit_done;
   logic          busy;
   logic [1:0]    user_bypass;
   logic          bypass_1MHz, bypass_2_4MHz;
   logic          coeff_wr_en_1MHz, coeff_wr_en_2_4MHz;
   logic [BW-1:0] coeff_out_1MHz, coeff_out_2_4MHz;
   logic          overflow_1MHz, underflow_1MHz, overflow_2_4MHz, underflow_2_4MHz;
   logic [2*CW-1:0] ovf_cnt, udf_cnt;

   int checks = 0;
   int errors = 0;

   iir_notch_coeff_ctrl #(.COEFF_WIDTH(W), .COEFF_DEPTH(D), .FLUSH_SAMPLES(N), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
      .commit_req(commit_req), .commit_done(commit_done), .busy(busy), .user_bypass(user_bypass),
      .bypass_1MHz(bypass_1MHz), .bypass_2_4MHz(bypass_2_4MHz),
      .coeff_wr_en_1MHz(coeff_wr_en_1MHz), .coeff_wr_en_2_4MHz(coeff_wr_en_2_4MHz),
      .coeff_out_1MHz(coeff_out_1MHz), .coeff_out_2_4MHz(coeff_out_2_4MHz),
      .overflow_1MHz(overflow_1MHz), .underflow_1MHz(underflow_1MHz),
      .overflow_2_4MHz(overflow_2_4MHz), .underflow_2_4MHz(underflow_2_4MHz),
      .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
   );

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 flushing, 2 loading, 3 settling; m_left counts remaining samples
   int           m_phase, m_left, m_g, m_prio;
   bit   [1:0]   m_pend, m_loaded;
   logic [W-1:0] m_bank [2][D];
   logic [CW-1:0] m_ovf [2];
   logic [CW-1:0] m_udf [2];
   bit           m_ready = 1'b0;
   bit           e_cfg_err, e_busy;
   bit   [1:0]   e_done, e_wr, e_byp;

   function automatic logic [BW-1:0] packBank(int b);
      logic [BW-1:0] v;
      for (int k = 0; k < D; k++) v[k*W +: W] = m_bank[b][k];
      return v;
   endfunction

   task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_left = 0; m_g = 0; m_prio = 1;
         m_pend = 0; m_loaded = 0;
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < D; k++) m_bank[b][k] = '0;
            m_ovf[b] = '0; m_udf[b] = '0;
         end
         e_cfg_err = 0; e_busy = 0; e_done = 0; e_wr = 0; e_byp = 2'b11;
         m_ready = 1'b1;
      end else if (m_ready) begin
         e_cfg_err = 0;
         e_done    = 0;
         if (cfg_wr_en) begin
            if (cfg_addr >= D || ((m_phase == 1 || m_phase == 2) && cfg_sel == m_g)) e_cfg_err = 1;
            else m_bank[cfg_sel][cfg_addr] = cfg_wdata;
         end
         case (m_phase)
            0: if (m_pend != 0) begin
                  m_g = (m_pend == 2'b11) ? m_prio : (m_pend[1] ? 1 : 0);
                  m_pend[m_g] = 1'b0;
                  m_phase = 1;
                  m_left  = N;
               end
            1: if (valid_in) begin
                  m_left--;
                  if (m_left == 0) m_phase = 2;
               end
            2: begin
                  m_loaded[m_g] = 1'b1;
                  m_phase = 3;
                  m_left  = N;
               end
            default: if (valid_in) begin
                  m_left--;
                  if (m_left == 0) begin
                     e_done[m_g] = 1'b1;
                     m_prio  = 1 - m_g;
                     m_phase = 0;
                  end
               end
         endcase
         m_pend = m_pend | commit_req;
         e_wr   = (m_phase == 2) ? (2'b01 << m_g) : 2'b00;
         e_busy = (m_phase != 0);
         for (int x = 0; x < 2; x++)
            e_byp[x] = user_bypass[x] | !m_loaded[x] | (m_phase != 0 && m_g == x);
`ifdef IIR_CTRL_OVF_MON_EN
         if (overflow_1MHz    && m_ovf[0] != '1) m_ovf[0]++;
         if (overflow_2_4MHz  && m_ovf[1] != '1) m_ovf[1]++;
         if (underflow_1MHz   && m_udf[0] != '1) m_udf[0]++;
         if (underflow_2_4MHz && m_udf[1] != '1) m_udf[1]++;
`endif
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         checkOutput("cfg_err", cfg_err, e_cfg_err);
         checkOutput("commit_done", commit_done, e_done);
         checkOutput("busy", busy, e_busy);
         checkOutput("bypass", {bypass_2_4MHz, bypass_1MHz}, e_byp);
         checkOutput("coeff_wr_en", {coeff_wr_en_2_4MHz, coeff_wr_en_1MHz}, e_wr);
         checkOutput("coeff_out_1MHz", coeff_out_1MHz, packBank(0));
         checkOutput("coeff_out_2_4MHz", coeff_out_2_4MHz, packBank(1));
         checkOutput("ovf_cnt", ovf_cnt, {m_ovf[1], m_ovf[0]});
         checkOutput("udf_cnt", udf_cnt, {m_udf[1], m_udf[0]});
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(bit wr, bit sel, logic [2:0] addr, logic [W-1:0] data, logic [1:0] req);
      cfg_wr_en = wr; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data; commit_req = req;
      tick(1);
      cfg_wr_en = 1'b0; commit_req = 2'b00;
   endtask

   task automatic driveUntilIdle(int budget, output logic [1:0] first_done);
      int  n  = 0;
      bit  ph = 1'b0;
      first_done = 2'b00;
      while (!(m_phase == 0 && m_pend == 0) && n < budget) begin
         valid_in = ph;
         ph = ~ph;
         tick(1);
         n++;
         if (first_done == 2'b00 && commit_done != 2'b00) first_done = commit_done;
      end
      valid_in = 1'b0;
      if (n >= budget) checkOutput("idle_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0] first;
      int n;
      rst = 1'b1; valid_in = 1'b0; cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      commit_req = 2'b00; user_bypass = 2'b00;
      overflow_1MHz = 0; underflow_1MHz = 0; overflow_2_4MHz = 0; underflow_2_4MHz = 0;

      tick(2);
      checkOutput("reset_bypass", {bypass_2_4MHz, bypass_1MHz}, 2'b11);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_coeff", {coeff_out_2_4MHz, coeff_out_1MHz}, 0);
      rst = 1'b0;
      tick(1);

      $display("[TB] single commit on the 1 MHz filter");
      applyStimulus(1, 0, 0, 20'h10000, 2'b00);
      applyStimulus(1, 0, 1, 20'h00001, 2'b00);
      applyStimulus(1, 0, 2, 20'h00002, 2'b00);
      applyStimulus(1, 0, 3, 20'h00003, 2'b00);
      applyStimulus(1, 0, 4, 20'hFFFFF, 2'b00);
      checkOutput("bank0_contents", coeff_out_1MHz, {20'hFFFFF, 20'h00003, 20'h00002, 20'h00001, 20'h10000});
      applyStimulus(0, 0, 0, 0, 2'b01);
      checkOutput("pending_not_busy", busy, 0);
      tick(1);
      checkOutput("flush_busy", busy, 1);
      checkOutput("flush_bypass0", bypass_1MHz, 1);
      for (int i = 0; i < N; i++) begin
         valid_in = 1'b1; tick(1);
         checkOutput("load_strobe", coeff_wr_en_1MHz, (i == N - 1) ? 1 : 0);
         valid_in = 1'b0; tick(1);
      end
      checkOutput("load_strobe_end", coeff_wr_en_1MHz, 0);
      for (int i = 0; i < N; i++) begin
         valid_in = 1'b1; tick(1);
         checkOutput("settle_done", commit_done, (i == N - 1) ? 2'b01 : 2'b00);
         valid_in = 1'b0;
         if (i == N - 1) checkOutput("release_bypass0", bypass_1MHz, 0);
         tick(1);
      end
      checkOutput("done_one_cycle", commit_done, 2'b00);
      user_bypass = 2'b01; tick(1);
      checkOutput("user_bypass0", bypass_1MHz, 1);
      user_bypass = 2'b00; tick(1);
      checkOutput("user_bypass0_off", bypass_1MHz, 0);

      $display("[TB] arbitration after reset");
      rst = 1'b1; tick(2); rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 2'b11);
      tick(1);
      checkOutput("arb_bypass1", bypass_2_4MHz, 1);
      driveUntilIdle(200, first);
      checkOutput("arb_first_after_reset", first, 2'b10);
      applyStimulus(0, 0, 0, 0, 2'b11);
      tick(1);
      checkOutput("arb_other_not_forced", bypass_1MHz, 0);
      driveUntilIdle(200, first);
      checkOutput("arb_round_robin", first, 2'b10);

      $display("[TB] rejected writes");
      applyStimulus(1, 0, 5, 20'h12345, 2'b00);
      checkOutput("bad_addr_err", cfg_err, 1);
      checkOutput("bad_addr_bank", coeff_out_1MHz, 0);
      applyStimulus(0, 0, 0, 0, 2'b10);
      tick(1);
      applyStimulus(1, 1, 0, 20'hABCDE, 2'b00);
      checkOutput("granted_bank_err", cfg_err, 1);
      checkOutput("granted_bank_kept", coeff_out_2_4MHz[W-1:0], 0);
      applyStimulus(1, 0, 2, 20'h0BEEF, 2'b00);
      checkOutput("other_bank_ok", cfg_err, 0);
      checkOutput("other_bank_val", coeff_out_1MHz[2*W +: W], 20'h0BEEF);
      tick(10);
      checkOutput("stall_busy", busy, 1);
      driveUntilIdle(200, first);

      $display("[TB] write and commit in the same cycle");
      applyStimulus(1, 1, 0, 20'h00777, 2'b10);
      driveUntilIdle(200, first);
      checkOutput("simul_write", coeff_out_2_4MHz[W-1:0], 20'h00777);
      checkOutput("simul_done", first, 2'b10);

      $display("[TB] reset during settle");
      rst = 1'b1; tick(1); rst = 1'b0; tick(1);
      applyStimulus(0, 0, 0, 0, 2'b01);
      n = 0;
      while (m_phase != 3 && n < 100) begin
         valid_in = ~valid_in; tick(1); n++;
      end
      if (n >= 100) checkOutput("settle_timeout", 1, 0);
      valid_in = 1'b1; tick(1);
      rst = 1'b1; valid_in = 1'b0; tick(1);
      checkOutput("midreset_done", commit_done, 2'b00);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_bypass", {bypass_2_4MHz, bypass_1MHz}, 2'b11);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         valid_in = ~valid_in; tick(1);
      end
      valid_in = 1'b0;
      checkOutput("midreset_stays_bypassed", bypass_1MHz, 1);

      $display("[TB] event counters");
      overflow_2_4MHz = 1'b1; tick(300); overflow_2_4MHz = 1'b0;
      underflow_1MHz  = 1'b1; tick(10);  underflow_1MHz  = 1'b0;
      tick(1);
`ifdef IIR_CTRL_OVF_MON_EN
      checkOutput("ovf_saturate", ovf_cnt[2*CW-1:CW], 8'd255);
      checkOutput("udf_count", udf_cnt[CW-1:0], 8'd10);
`else
      checkOutput("ovf_disabled", ovf_cnt[2*CW-1:CW], 8'd0);
      checkOutput("udf_disabled", udf_cnt[CW-1:0], 8'd0);
`endif

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
